// File: rtl/exu_dispatch.sv
// exu_dispatch: IFU-fed FIFO that decodes its head into one-hot EXU handler selects and retires in order
module exu_dispatch #(
  parameter int DEPTH = 2,
  parameter int RV_PC_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_vld,
  output logic                  ifu_rdy,
  input  logic [31:0]           ifu_inst,
  input  logic [RV_PC_SIZE-1:0] ifu_pc,
  output logic [31:0]           inst,
  output logic [RV_PC_SIZE-1:0] pc,
  output logic                  sel_alu,
  output logic                  sel_misc,
  output logic                  sel_br,
  output logic                  sel_lsu,
  input  logic                  lsu_done,
  input  logic                  flush,
  output logic                  retire,
  output logic                  halt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0]           inst_q [DEPTH];
  logic [RV_PC_SIZE-1:0] pc_q [DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr, rd_nxt, wr_nxt;
  logic [CW-1:0]         count;
  logic [6:0]            op;
  logic                  is_alu, is_misc, is_br, is_lsu, is_fence;
  logic                  nonempty, act, illegal_head, push, flushing;
  // Head view, opcode decode, retire and flush qualification
  always_comb begin
    inst         = inst_q[rd_ptr];
    pc           = pc_q[rd_ptr];
    op           = inst[6:0];
    is_misc      = op == 7'b0110111 || op == 7'b0010111;
    is_br        = op == 7'b1101111 || op == 7'b1100111 || op == 7'b1100011;
    is_lsu       = op == 7'b0000011 || op == 7'b0100011;
    is_alu       = op == 7'b0010011 || op == 7'b0110011;
    is_fence     = op == 7'b0001111;
    nonempty     = count != '0;
    act          = nonempty && !halt;
    illegal_head = nonempty && !(is_misc || is_br || is_lsu || is_alu || is_fence);
    sel_alu      = act && is_alu;
    sel_misc     = act && is_misc;
    sel_br       = act && is_br;
    sel_lsu      = act && is_lsu;
    retire       = act && !illegal_head && (!sel_lsu || lsu_done);
    flushing     = retire && sel_br && flush;
    ifu_rdy      = !rst && count != CW'(DEPTH);
    push         = ifu_vld && ifu_rdy && !flushing;
    rd_nxt       = rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
    wr_nxt       = wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
  end
  // FIFO storage, pointers, occupancy and sticky illegal-instruction halt
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      halt   <= 1'b0;
    end else begin
      halt <= halt || illegal_head;
      if (push) begin
        inst_q[wr_ptr] <= ifu_inst;
        pc_q[wr_ptr]   <= ifu_pc;
        wr_ptr         <= wr_nxt;
      end
      if (flushing) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (retire) rd_ptr <= rd_nxt;
        count <= count + CW'(push) - CW'(retire);
      end
    end
  end
endmodule

// File: tb/tb_exu_dispatch.sv
// tb_exu_dispatch: directed stimulus with a retire-order scoreboard for exu_dispatch
module tb_exu_dispatch;
  localparam int DEPTH = 3;
  localparam logic [31:0] ADDI = 32'h00100093, LUI = 32'h123450B7, LW = 32'h0000A103;
  localparam logic [31:0] ADD = 32'h002081B3, JAL = 32'h0000006F, ECALL = 32'h00000073;
  localparam logic [31:0] ORI = 32'h0020E193;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [3:0]  sel;
  } item_t;
  logic        clk = 0, rst, ifu_vld, ifu_rdy, lsu_done, flush, retire, halt;
  logic        sel_alu, sel_misc, sel_br, sel_lsu;
  logic [31:0] ifu_inst, ifu_pc, inst, pc;
  item_t       q[$];
  int          nvec = 0, nerr = 0;
  exu_dispatch #(.DEPTH(DEPTH), .RV_PC_SIZE(32)) dut (
    .clk(clk), .rst(rst), .ifu_vld(ifu_vld), .ifu_rdy(ifu_rdy), .ifu_inst(ifu_inst),
    .ifu_pc(ifu_pc), .inst(inst), .pc(pc), .sel_alu(sel_alu), .sel_misc(sel_misc),
    .sel_br(sel_br), .sel_lsu(sel_lsu), .lsu_done(lsu_done), .flush(flush),
    .retire(retire), .halt(halt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_sel(input string name, input logic [3:0] exp);
    chk(name, 32'({sel_alu, sel_misc, sel_br, sel_lsu}), 32'(exp));
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic [31:0] i, input logic [31:0] p, input logic [3:0] s, input bit exp);
    ifu_vld  = 1;
    ifu_inst = i;
    ifu_pc   = p;
    if (exp) q.push_back('{inst: i, pc: p, sel: s});
  endtask
  // Scoreboard monitor: every retire must match the oldest expected instruction
  always @(negedge clk) begin
    if (!rst && retire) begin
      nvec++;
      if (q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_retire: got inst %h pc %h expected no retire", inst, pc);
      end else begin
        item_t e;
        e = q.pop_front();
        if ({inst, pc, sel_alu, sel_misc, sel_br, sel_lsu} !== e) begin
          nerr++;
          $display("FAIL retire_item: got %h/%h/%b expected %h/%h/%b", inst, pc,
                   {sel_alu, sel_misc, sel_br, sel_lsu}, e.inst, e.pc, e.sel);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1; ifu_vld = 0; ifu_inst = 0; ifu_pc = 0; lsu_done = 0; flush = 0;
    cyc();
    @(negedge clk);
    chk("rst_rdy", 32'(ifu_rdy), 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc", pc, 0);
    chk_sel("rst_sel", 4'b0000);
    chk("rst_retire", 32'(retire), 0);
    chk("rst_halt", 32'(halt), 0);
    cyc();
    rst = 0;
    // ADDI then LUI back to back
    offer(ADDI, 32'h0, 4'b1000, 1);
    @(negedge clk); chk("t1_rdy", 32'(ifu_rdy), 1); chk_sel("t1_empty", 4'b0000);
    cyc();
    offer(LUI, 32'h4, 4'b0100, 1);
    @(negedge clk); chk_sel("t1_alu", 4'b1000); chk("t1_ret0", 32'(retire), 1); chk("t1_pc0", pc, 0);
    cyc();
    ifu_vld = 0;
    @(negedge clk); chk_sel("t1_misc", 4'b0100); chk("t1_ret1", 32'(retire), 1); chk("t1_inst1", inst, LUI);
    cyc();
    @(negedge clk); chk_sel("t1_idle", 4'b0000); chk("t1_ret2", 32'(retire), 0);
    // LW held three cycles while FIFO fills
    offer(LW, 32'h20, 4'b0001, 1);
    cyc();
    offer(ADD, 32'h24, 4'b1000, 1);
    @(negedge clk); chk_sel("t2_lsu0", 4'b0001); chk("t2_ret0", 32'(retire), 0);
    cyc();
    offer(ADDI, 32'h28, 4'b1000, 1);
    @(negedge clk); chk_sel("t2_lsu1", 4'b0001); chk("t2_pc1", pc, 32'h20);
    cyc();
    offer(ORI, 32'h2C, 4'b1000, 1);
    @(negedge clk); chk_sel("t2_lsu2", 4'b0001); chk("t2_full", 32'(ifu_rdy), 0); chk("t2_ret2", 32'(retire), 0);
    cyc();
    lsu_done = 1;
    @(negedge clk); chk_sel("t2_lsu3", 4'b0001); chk("t2_inst3", inst, LW); chk("t2_done", 32'(retire), 1);
    chk("t2_full_pop", 32'(ifu_rdy), 0);
    cyc();
    lsu_done = 0;
    @(negedge clk); chk("t2_rdy_back", 32'(ifu_rdy), 1); chk_sel("t2_add", 4'b1000);
    cyc();
    ifu_vld = 0;
    cyc(); cyc();
    @(negedge clk); chk_sel("t2_drained", 4'b0000);
    cyc();
    // Taken-branch flush drops buffered and simultaneous pushes
    offer(LW, 32'h0C, 4'b0001, 1);
    cyc();
    offer(JAL, 32'h10, 4'b0010, 1);
    cyc();
    offer(ADD, 32'h14, 4'b1000, 0);
    cyc();
    offer(ADD, 32'h18, 4'b1000, 0);
    lsu_done = 1;
    @(negedge clk); chk("t3_full", 32'(ifu_rdy), 0); chk("t3_lw_ret", 32'(retire), 1);
    cyc();
    lsu_done = 0; flush = 1;
    @(negedge clk); chk_sel("t3_br", 4'b0010); chk("t3_pc", pc, 32'h10); chk("t3_rdy", 32'(ifu_rdy), 1);
    cyc();
    flush = 0; ifu_vld = 0;
    @(negedge clk); chk_sel("t3_flushed", 4'b0000); chk("t3_noret", 32'(retire), 0); chk("t3_rdy2", 32'(ifu_rdy), 1);
    cyc();
    @(negedge clk); chk_sel("t3_still_empty", 4'b0000);
    // Flush with a non-branch head is ignored
    offer(ADD, 32'h40, 4'b1000, 1);
    cyc();
    offer(ADDI, 32'h44, 4'b1000, 1);
    flush = 1;
    @(negedge clk); chk_sel("t4_add", 4'b1000);
    cyc();
    ifu_vld = 0;
    @(negedge clk); chk_sel("t4_addi", 4'b1000); chk("t4_pc", pc, 32'h44);
    cyc();
    flush = 0;
    // Illegal ECALL halts the stage
    offer(ECALL, 32'h50, 4'b0000, 0);
    cyc();
    offer(ADD, 32'h54, 4'b1000, 0);
    @(negedge clk); chk_sel("t5_ill_sel", 4'b0000); chk("t5_ill_ret", 32'(retire), 0); chk("t5_halt0", 32'(halt), 0);
    cyc();
    offer(ADD, 32'h58, 4'b1000, 0);
    flush = 1;
    @(negedge clk); chk("t5_halt1", 32'(halt), 1); chk_sel("t5_sel", 4'b0000); chk("t5_ret", 32'(retire), 0);
    cyc();
    offer(ADD, 32'h5C, 4'b1000, 0);
    flush = 0;
    @(negedge clk); chk("t5_full", 32'(ifu_rdy), 0); chk("t5_halt2", 32'(halt), 1);
    cyc();
    ifu_vld = 0; rst = 1;
    cyc();
    rst = 0;
    @(negedge clk); chk("t5_halt_clr", 32'(halt), 0); chk("t5_rdy", 32'(ifu_rdy), 1);
    chk("t5_inst0", inst, 0); chk("t5_pc0", pc, 0);
    cyc();
    // Reset while an LSU op waits at the head
    offer(LW, 32'h60, 4'b0001, 0);
    cyc();
    ifu_vld = 0;
    @(negedge clk); chk_sel("t6_lsu", 4'b0001);
    cyc();
    rst = 1;
    cyc();
    rst = 0; lsu_done = 1;
    @(negedge clk); chk_sel("t6_sel", 4'b0000); chk("t6_rdy", 32'(ifu_rdy), 1); chk("t6_ret", 32'(retire), 0);
    cyc();
    lsu_done = 0;
    @(negedge clk); chk_sel("t6_idle", 4'b0000);
    cyc();
    chk("sb_drained", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/exu_dispatch.md
# exu_dispatch

Instruction dispatch stage directly upstream of the EXU handlers. It buffers fetched instructions and their PCs from the IFU in a small FIFO. It decodes the head opcode into one-hot handler selects (ALU, MISC for LUI/AUIPC, BR, LSU) and presents the head `inst`/`pc` to all handlers. It holds multi-cycle LSU operations until completion, drops younger instructions on a taken-branch flush, and halts on an illegal instruction.

## Interface
Parameters:
- `DEPTH`, default 2: number of FIFO entries (≥2).

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  synchronous reset, active-high
- `ifu_vld`  in  1  IFU offers an instruction
- `ifu_rdy`  out  1  dispatch can accept one instruction
- `ifu_inst`  in  32  fetched instruction word
- `ifu_pc`  in  `RV_PC_SIZE`  PC of `ifu_inst`
- `inst`  out  32  head instruction, broadcast to all handlers
- `pc`  out  `RV_PC_SIZE`  head PC
- `sel_alu`  out  1  head is OP or OP-IMM
- `sel_misc`  out  1  head is LUI or AUIPC
- `sel_br`  out  1  head is JAL, JALR or BRANCH
- `sel_lsu`  out  1  head is LOAD or STORE
- `lsu_done`  in  1  LSU handler finishes the head operation this cycle
- `flush`  in  1  BR handler requests a redirect (taken branch/jump) this cycle
- `retire`  out  1  head completes and pops this cycle
- `halt`  out  1  sticky illegal-instruction halt

## Operation
- Storage is a circular FIFO of {inst, pc}. It has `rd_ptr`, `wr_ptr` (wrap at DEPTH) and `count` (width `$clog2(DEPTH+1)`).
- Push occurs on `ifu_vld && ifu_rdy`.
- `ifu_rdy = !rst && (count != DEPTH)`. It does not depend on `retire`, `lsu_done` or `flush`.
- Head decode uses `inst[6:0]`, with `inst[1:0]` required to be 2'b11:
  - LUI 0110111 and AUIPC 0010111 → misc
  - JAL 1101111, JALR 1100111 and BRANCH 1100011 → br
  - LOAD 0000011 and STORE 0100011 → lsu
  - OP-IMM 0010011 and OP 0110011 → alu
  - MISC-MEM 0001111 (FENCE) → no select; retires as a NOP
  - Anything else, including SYSTEM → illegal
- The `sel_*` outputs are one-hot or all-zero. All are 0 when the FIFO is empty, when the head is FENCE, when the head is illegal, or when `halt` is set.
- `inst`/`pc` always show the head entry. Storage resets to zero, so both outputs read 0 after reset.
- Retire rule: `retire = (count!=0) && !halt && !illegal_head && (!sel_lsu || lsu_done)`. ALU, MISC, BR and FENCE heads therefore retire in their first cycle at the head.
- LSU head: the entry and `sel_lsu` stay stable until the cycle `lsu_done=1`.
  - `lsu_done` is ignored when the head is not LSU or the FIFO is empty.
- Flush: `flush` is honoured only when `retire && sel_br`. The branch itself retires, `count` is set to 0, and `rd_ptr` is set equal to `wr_ptr`. Any push in that same cycle is discarded. `flush` is ignored in all other cycles.
- Illegal head: the entry is not popped and `halt` is set on the next edge. `halt` stays at 1 until `rst`. While halted there is no retire and flush is ignored. The IFU may keep filling the FIFO until it is full.
- Reset clears pointers, `count`, `halt` and storage. Reset mid-LSU discards the pending op without waiting for `lsu_done`.

## Timing
- Reset values: `ifu_rdy`=0 while `rst`=1. `inst`, `pc`, all `sel_*`, `retire` and `halt` are 0.
- Accept-to-head latency is 1 cycle. An instruction pushed at edge N is at the head and selected in cycle N+1. There is no bypass from `ifu_inst`.
- Throughput: 1 instruction/cycle sustained for non-LSU streams when DEPTH≥2.
- `sel_*`, `inst`, `pc` and `retire` are combinational from registered state plus `lsu_done`. `flush` only affects state at the next edge.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Full FIFO with retire: no push that cycle, because `ifu_rdy` was 0; `ifu_rdy` rises the following cycle.
- `halt` asserts 1 cycle after the illegal instruction reaches the head.

## Test plan
- Reset then push ADDI (0x00100093, pc 0x0) followed by LUI (0x123450B7, pc 0x4) on consecutive cycles → `sel_alu` is high the cycle after the first push and `sel_misc` the next. `retire` is high in both cycles. Empty afterwards with all selects 0.
- LW at head with `lsu_done` low for 3 cycles → `sel_lsu`, `inst` and `pc` are stable for 4 cycles. `retire` goes high only in the `lsu_done` cycle. FIFO fills to DEPTH and `ifu_rdy`=0 until the pop.
- JAL (pc 0x10) at head with ADD (pc 0x14) buffered, `flush`=1 and a simultaneous push (pc 0x18) → JAL retires, the next cycle `count`=0 and all selects are 0, and neither 0x14 nor 0x18 is ever selected.
- `flush`=1 while the head is ADD → ignored, and the ADD and younger entries issue normally.
- Push 0x00000073 (ECALL) then ADD → `halt` is 1 the cycle after ECALL reaches the head. No selects and no retire afterwards. `ifu_rdy` drops when DEPTH entries are held. `rst` clears `halt`.
- Assert `rst` for one cycle while LW waits at the head → next cycle `count`=0, `sel_lsu`=0, `ifu_rdy`=1, and a later `lsu_done` has no effect.
